// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled 8N1 UART receiver with a one-byte holding register
// A 2/3-FF synchroniser feeds a mid-bit sampler; glitch, framing and overrun checks included.
module uart_rx #(
    parameter int OVERSAMPLE_DIV = 326,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tcnt;
    logic                   tick;
    logic [3:0]             s_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    logic start_edge;
    logic mid_start;
    logic bit_end;
    logic shift_en;
    logic deliver;
    logic ferr_set;

    // Flops reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (tcnt == TICK_MAX);

    // Restarting the divider at the start edge puts every later sample mid-bit.
    always_ff @(posedge clk) begin
        if (rst || start_edge || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (mid_start) begin
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (shift_en && (bit_idx == 3'd7)) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_nxt = rx_s ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_edge = 1'b0;
        mid_start  = 1'b0;
        bit_end    = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            ST_IDLE:  start_edge = !rx_s;
            ST_START: mid_start  = tick && (s_cnt == 4'd7);
            ST_DATA: begin
                bit_end  = tick && (s_cnt == 4'd15);
                shift_en = bit_end;
            end
            ST_STOP: begin
                bit_end  = tick && (s_cnt == 4'd15);
                deliver  = bit_end && rx_s;
                ferr_set = bit_end && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cnt <= 4'd0;
        end else begin
            case (state)
                ST_START: begin
                    if (mid_start) begin
                        s_cnt <= 4'd0;
                    end else if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                    end
                end
                ST_DATA, ST_STOP: begin
                    if (bit_end) begin
                        s_cnt <= 4'd0;
                    end else if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                    end
                end
                default: s_cnt <= 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (mid_start) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // A delivery that coincides with a consume replaces the byte without loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized self-checking bench for uart_rx
// Frames are driven at 64 clk per bit; a monitor logs accepted bytes and flag pulses.
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;
    // Start bit driven just after edge P is delivered at edge P + 611 (2 sync + 1 + 8 + 9*16 ticks).
    localparam int DELIVER_EDGE = 611;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int valid_cycles = 0;
    logic [7:0] got[$];

    int base_ferr;
    int base_ovr;
    int base_valid;
    int base_got;

    always #5 clk = ~clk;

    uart_rx #(
        .OVERSAMPLE_DIV(DIV),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        base_ferr  = ferr_cnt;
        base_ovr   = ovr_cnt;
        base_valid = valid_cycles;
        base_got   = got.size();
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (base_got + i < got.size()) return 32'(got[base_got + i]);
        return 32'hDEAD;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
        rx = stop_bit;
        wait_clk(stop_len);
        rx = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(rx_data), 32'h0);
        check({tag, "_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_ferr"}, 32'(frame_err), 32'h0);
        check({tag, "_ovr"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] b;

        // Reset state
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check_outputs_zero("reset");

        // 1: single byte with consumer ready
        rx_ready = 1'b1;
        mark();
        send_frame(8'hA5, 1'b1, BIT);
        wait_clk(20);
        check("t1_count", 32'(got.size() - base_got), 32'd1);
        check("t1_byte", got_at(0), 32'hA5);
        check("t1_valid_cycles", 32'(valid_cycles - base_valid), 32'd1);
        check("t1_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        check("t1_ovr", 32'(ovr_cnt - base_ovr), 32'd0);

        // 2: short low glitch is rejected, next frame still received
        mark();
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(100);
        check("t2_glitch_bytes", 32'(got.size() - base_got), 32'd0);
        check("t2_glitch_valid", 32'(valid_cycles - base_valid), 32'd0);
        check("t2_glitch_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        send_frame(8'h3C, 1'b1, BIT);
        wait_clk(20);
        check("t2_byte", got_at(0), 32'h3C);

        // 3: framing error with held-low line, then recovery
        mark();
        send_frame(8'h3C, 1'b0, 3 * BIT);
        wait_clk(2 * BIT);
        check("t3_ferr", 32'(ferr_cnt - base_ferr), 32'd1);
        check("t3_no_byte", 32'(got.size() - base_got), 32'd0);
        send_frame(8'h11, 1'b1, BIT);
        wait_clk(20);
        check("t3_count", 32'(got.size() - base_got), 32'd1);
        check("t3_byte", got_at(0), 32'h11);
        check("t3_ferr_total", 32'(ferr_cnt - base_ferr), 32'd1);

        // 4: overrun while holding register is full
        rx_ready = 1'b0;
        mark();
        send_frame(8'h01, 1'b1, BIT);
        send_frame(8'h02, 1'b1, BIT);
        wait_clk(20);
        check("t4_valid", 32'(rx_valid), 32'h1);
        check("t4_data", 32'(rx_data), 32'h01);
        check("t4_ovr", 32'(ovr_cnt - base_ovr), 32'd1);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("t4_drained_valid", 32'(rx_valid), 32'h0);
        check("t4_drained_data", 32'(rx_data), 32'h01);
        check("t4_drained_byte", got_at(0), 32'h01);

        // 5: consume on the exact delivery cycle
        send_frame(8'h55, 1'b1, BIT);
        wait_clk(20);
        check("t5_held", 32'(rx_data), 32'h55);
        mark();
        fork
            send_frame(8'hAA, 1'b1, BIT);
            begin
                wait_clk(DELIVER_EDGE - 1);
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
            end
        join
        wait_clk(10);
        check("t5_valid", 32'(rx_valid), 32'h1);
        check("t5_data", 32'(rx_data), 32'hAA);
        check("t5_ovr", 32'(ovr_cnt - base_ovr), 32'd0);
        check("t5_consumed", got_at(0), 32'h55);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check("t5_drained", got_at(1), 32'hAA);

        // 6: reset mid-frame
        rx_ready = 1'b1;
        mark();
        fork
            send_frame(8'hFF, 1'b1, BIT);
            begin
                wait_clk(4 * BIT + 8);
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                check_outputs_zero("t6_after_rst");
            end
        join
        wait_clk(100);
        send_frame(8'h5A, 1'b1, BIT);
        wait_clk(20);
        check("t6_count", 32'(got.size() - base_got), 32'd1);
        check("t6_byte", got_at(0), 32'h5A);
        check("t6_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        check("t6_ovr", 32'(ovr_cnt - base_ovr), 32'd0);

        // Randomized bytes and idle gaps against an expected-byte queue
        rx_ready = 1'b1;
        mark();
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, BIT + int'($urandom_range(0, 30)));
        end
        wait_clk(20);
        check("rand_count", 32'(got.size() - base_got), 32'(exp_q.size()));
        for (int n = 0; n < exp_q.size(); n++) begin
            check($sformatf("rand_byte%0d", n), got_at(n), 32'(exp_q[n]));
        end
        check("rand_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
        check("rand_ovr", 32'(ovr_cnt - base_ovr), 32'd0);

        check("flags_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
